// File: rtl/mem_write_buffer.sv
// mem_write_buffer: writeback buffer between the last-level cache and main memory.
//   Absorbs cache writebacks into a DEPTH-entry FIFO and acknowledges them
//   immediately. Read requests are served from the youngest matching buffered
//   writeback. Reads that miss the buffer go to memory ahead of the drain.
//   Exactly one memory request is outstanding at a time.
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   cache_msg/address/data_in  request from the cache (R_REQ / WB_REQ / NO_REQ)
//   cache_msg/address/data_out one-cycle MEM_RESP back to the cache
//   mem_msg/address/data_out   request to main memory, held until answered
//   mem_msg/address/data_in    response from main memory (address unused)
//   full, empty                FIFO occupancy flags (registered)
module mem_write_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS      = 4,
  parameter int DEPTH         = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MSG_BITS-1:0]      cache_msg_in,
  input  logic [ADDRESS_WIDTH-1:0] cache_address_in,
  input  logic [DATA_WIDTH-1:0]    cache_data_in,
  output logic [MSG_BITS-1:0]      cache_msg_out,
  output logic [ADDRESS_WIDTH-1:0] cache_address_out,
  output logic [DATA_WIDTH-1:0]    cache_data_out,
  output logic [MSG_BITS-1:0]      mem_msg_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic [MSG_BITS-1:0]      mem_msg_in,
  input  logic [ADDRESS_WIDTH-1:0] mem_address_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     full,
  output logic                     empty
);

  localparam logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0);
  localparam logic [MSG_BITS-1:0] WB_REQ   = MSG_BITS'(1);
  localparam logic [MSG_BITS-1:0] R_REQ    = MSG_BITS'(2);
  localparam logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(3);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {C_IDLE, C_RESP, C_WAIT_RD} c_state_e;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_GAP} m_state_e;

  c_state_e c_state_q, c_state_d;
  m_state_e m_state_q, m_state_d;

  logic [ADDRESS_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     full_q, full_d, empty_q, empty_d;

  logic                     rd_pending_q, rd_pending_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     mem_is_rd_q, mem_is_rd_d;

  logic [MSG_BITS-1:0]      cache_msg_out_q, cache_msg_out_d;
  logic [ADDRESS_WIDTH-1:0] cache_address_out_q, cache_address_out_d;
  logic [DATA_WIDTH-1:0]    cache_data_out_q, cache_data_out_d;
  logic [MSG_BITS-1:0]      mem_msg_out_q, mem_msg_out_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_out_q, mem_address_out_d;
  logic [DATA_WIDTH-1:0]    mem_data_out_q, mem_data_out_d;

  logic                     hit;
  logic [DATA_WIDTH-1:0]    hit_data;
  logic [PTR_W-1:0]         idx;
  logic                     mem_resp, rd_done, wb_done, enq;

  // The memory response address carries nothing we need.
  logic unused_mem_address;
  assign unused_mem_address = ^mem_address_in;

  // Walk valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((i < 32'(count_q)) && (fifo_addr_q[idx] == cache_address_in)) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
  end

  always_comb begin
    c_state_d           = c_state_q;
    m_state_d           = m_state_q;
    fifo_addr_d         = fifo_addr_q;
    fifo_data_d         = fifo_data_q;
    wr_ptr_d            = wr_ptr_q;
    rd_ptr_d            = rd_ptr_q;
    count_d             = count_q;
    rd_pending_d        = rd_pending_q;
    rd_addr_d           = rd_addr_q;
    mem_is_rd_d         = mem_is_rd_q;
    cache_msg_out_d     = NO_REQ;
    cache_address_out_d = cache_address_out_q;
    cache_data_out_d    = cache_data_out_q;
    mem_msg_out_d       = mem_msg_out_q;
    mem_address_out_d   = mem_address_out_q;
    mem_data_out_d      = mem_data_out_q;
    enq                 = 1'b0;

    mem_resp = (m_state_q == M_REQ) && (mem_msg_in == MEM_RESP);
    rd_done  = mem_resp && mem_is_rd_q;
    wb_done  = mem_resp && !mem_is_rd_q;

    unique case (c_state_q)
      C_IDLE: begin
        if (cache_msg_in == WB_REQ) begin
          // A full FIFO still accepts when the head retires on this edge.
          if ((count_q != CNT_FULL) || wb_done) begin
            enq                 = 1'b1;
            cache_msg_out_d     = MEM_RESP;
            cache_address_out_d = cache_address_in;
            cache_data_out_d    = '0;
            c_state_d           = C_RESP;
          end
        end else if (cache_msg_in == R_REQ) begin
          if (hit) begin
            cache_msg_out_d     = MEM_RESP;
            cache_address_out_d = cache_address_in;
            cache_data_out_d    = hit_data;
            c_state_d           = C_RESP;
          end else begin
            rd_pending_d = 1'b1;
            rd_addr_d    = cache_address_in;
            c_state_d    = C_WAIT_RD;
          end
        end
      end
      C_RESP: c_state_d = C_IDLE;
      C_WAIT_RD: begin
        if (rd_done) begin
          cache_msg_out_d     = MEM_RESP;
          cache_address_out_d = rd_addr_q;
          cache_data_out_d    = mem_data_in;
          c_state_d           = C_RESP;
        end
      end
      default: c_state_d = C_IDLE;
    endcase

    unique case (m_state_q)
      M_IDLE: begin
        if (rd_pending_q) begin
          mem_msg_out_d     = R_REQ;
          mem_address_out_d = rd_addr_q;
          mem_data_out_d    = '0;
          mem_is_rd_d       = 1'b1;
          m_state_d         = M_REQ;
        end else if (count_q != '0) begin
          mem_msg_out_d     = WB_REQ;
          mem_address_out_d = fifo_addr_q[rd_ptr_q];
          mem_data_out_d    = fifo_data_q[rd_ptr_q];
          mem_is_rd_d       = 1'b0;
          m_state_d         = M_REQ;
        end
      end
      M_REQ: begin
        if (mem_resp) begin
          mem_msg_out_d     = NO_REQ;
          mem_address_out_d = '0;
          mem_data_out_d    = '0;
          m_state_d         = M_GAP;
          if (mem_is_rd_q) rd_pending_d = 1'b0;
        end
      end
      M_GAP: m_state_d = M_IDLE;
      default: m_state_d = M_IDLE;
    endcase

    // When full, wr_ptr equals rd_ptr: the slot written is the head retiring now.
    if (enq) begin
      fifo_addr_d[wr_ptr_q] = cache_address_in;
      fifo_data_d[wr_ptr_q] = cache_data_in;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (wb_done) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({enq, wb_done})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_state_q           <= C_IDLE;
      m_state_q           <= M_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      full_q              <= 1'b0;
      empty_q             <= 1'b1;
      rd_pending_q        <= 1'b0;
      rd_addr_q           <= '0;
      mem_is_rd_q         <= 1'b0;
      cache_msg_out_q     <= NO_REQ;
      cache_address_out_q <= '0;
      cache_data_out_q    <= '0;
      mem_msg_out_q       <= NO_REQ;
      mem_address_out_q   <= '0;
      mem_data_out_q      <= '0;
    end else begin
      c_state_q           <= c_state_d;
      m_state_q           <= m_state_d;
      fifo_addr_q         <= fifo_addr_d;
      fifo_data_q         <= fifo_data_d;
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      count_q             <= count_d;
      full_q              <= full_d;
      empty_q             <= empty_d;
      rd_pending_q        <= rd_pending_d;
      rd_addr_q           <= rd_addr_d;
      mem_is_rd_q         <= mem_is_rd_d;
      cache_msg_out_q     <= cache_msg_out_d;
      cache_address_out_q <= cache_address_out_d;
      cache_data_out_q    <= cache_data_out_d;
      mem_msg_out_q       <= mem_msg_out_d;
      mem_address_out_q   <= mem_address_out_d;
      mem_data_out_q      <= mem_data_out_d;
    end
  end

  assign cache_msg_out     = cache_msg_out_q;
  assign cache_address_out = cache_address_out_q;
  assign cache_data_out    = cache_data_out_q;
  assign mem_msg_out       = mem_msg_out_q;
  assign mem_address_out   = mem_address_out_q;
  assign mem_data_out      = mem_data_out_q;
  assign full              = full_q;
  assign empty             = empty_q;

endmodule
